// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer blocks: FSM encoding,
// fixed-point constants and the requantise/saturate helper.
package fc_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACC   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int FRAC_BITS = 16;
  localparam int COEFF_W   = 17;
  localparam int REQ_W     = 64;

  localparam logic signed [REQ_W-1:0] RND_HALF = 64'sd1 <<< (FRAC_BITS - 1);

  // Round-half-up rescale of a Q.16 product, optional ReLU, then clamp to a
  // signed dw-bit range. The caller keeps the low dw bits of the result.
  function automatic logic signed [REQ_W-1:0] requant_sat(
    input logic signed [REQ_W-1:0] prod,
    input logic                    relu,
    input int unsigned             dw
  );
    logic signed [REQ_W-1:0] rnd;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    rnd = (prod + RND_HALF) >>> FRAC_BITS;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (relu && rnd[REQ_W-1]) begin
      rnd = '0;
    end
    if (rnd > hi) begin
      rnd = hi;
    end else if (rnd < lo) begin
      rnd = lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear (priority over
// enable); the full product is sign-extended into the accumulator.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc_q;

  assign prod  = PW'(a_i) * PW'(b_i);
  assign acc_o = acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: MAC_NUM lanes accumulate one neuron group per
// pass, then results are requantised lane by lane into an internal buffer.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int IN_LEN     = 64,
  parameter int OUT_NUM    = 32,
  parameter int MAC_NUM    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(IN_LEN)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic                                         relu_en_i,
  input  logic [COEFF_W-1:0]                           coeff_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         x_en_o,
  output logic [$clog2(IN_LEN)-1:0]                    x_addr_o,
  input  logic signed [DATA_WIDTH-1:0]                 x_data_i,
  output logic                                         w_en_o,
  output logic [$clog2(IN_LEN*OUT_NUM/MAC_NUM)-1:0]    w_addr_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]                w_data_i,
  input  logic                                         rd_en_i,
  input  logic [$clog2(OUT_NUM)-1:0]                   rd_addr_i,
  output logic [DATA_WIDTH-1:0]                        rd_data_o
);

  localparam int GROUPS = OUT_NUM / MAC_NUM;
  localparam int LEN_W  = $clog2(IN_LEN);
  localparam int W_AW   = $clog2(IN_LEN * GROUPS);
  localparam int OA_W   = $clog2(OUT_NUM);
  localparam int LANE_W = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PROD_W = ACC_WIDTH + COEFF_W + 1;

  if ((OUT_NUM % MAC_NUM) != 0) begin : g_bad_groups
    $error("fc_layer_engine: OUT_NUM must be a multiple of MAC_NUM");
  end
  if (PROD_W > REQ_W) begin : g_bad_width
    $error("fc_layer_engine: requant product exceeds helper width");
  end

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [W_AW-1:0]    waddr_q, waddr_d;
  logic [GRP_W-1:0]   g_q, g_d;
  logic [LANE_W-1:0]  j_q, j_d;
  logic [OA_W-1:0]    oaddr_q, oaddr_d;
  logic               relu_q, relu_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d;
  logic               acc_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic lane_clr;
  logic buf_we;
  logic j_last;
  logic g_last;

  logic signed [ACC_WIDTH-1:0]  acc_lane [MAC_NUM];
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic signed [PROD_W-1:0]     prod_w;
  logic signed [REQ_W-1:0]      req_full;
  logic [DATA_WIDTH-1:0]        wr_data;

  logic [DATA_WIDTH-1:0] buf_mem [OUT_NUM];

  assign j_last = (j_q == LANE_W'(MAC_NUM - 1));
  assign g_last = (g_q == GRP_W'(GROUPS - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    waddr_d = waddr_q;
    g_d     = g_q;
    j_d     = j_q;
    oaddr_d = oaddr_q;
    relu_d  = relu_q;
    coeff_d = coeff_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACC;
          k_d     = '0;
          waddr_d = '0;
          g_d     = '0;
          j_d     = '0;
          oaddr_d = '0;
          relu_d  = relu_en_i;
          coeff_d = coeff_i;
        end
      end
      ST_ACC: begin
        // The weight address simply runs on across groups: group g starts at g*IN_LEN.
        waddr_d = waddr_q + W_AW'(1);
        if (k_q == LEN_W'(IN_LEN - 1)) begin
          k_d     = '0;
          state_d = ST_FLUSH;
        end else begin
          k_d = k_q + LEN_W'(1);
        end
      end
      ST_FLUSH: begin
        j_d     = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        oaddr_d = oaddr_q + OA_W'(1);
        if (j_last) begin
          j_d = '0;
          if (g_last) begin
            state_d = ST_DONE;
          end else begin
            g_d     = g_q + GRP_W'(1);
            state_d = ST_ACC;
          end
        end else begin
          j_d = j_q + LANE_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      waddr_q   <= '0;
      g_q       <= '0;
      j_q       <= '0;
      oaddr_q   <= '0;
      relu_q    <= 1'b0;
      coeff_q   <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      waddr_q   <= waddr_d;
      g_q       <= g_d;
      j_q       <= j_d;
      oaddr_q   <= oaddr_d;
      relu_q    <= relu_d;
      coeff_q   <= coeff_d;
      // Read data lands one cycle after the request, so the lanes add one cycle late.
      acc_vld_q <= (state_q == ST_ACC);
    end
  end

  assign lane_clr = ((state_q == ST_IDLE) && start_i) || ((state_q == ST_DRAIN) && j_last);

  for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_lane
    fc_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(lane_clr),
      .en_i (acc_vld_q),
      .a_i  (x_data_i),
      .b_i  ($signed(w_data_i[gi*DATA_WIDTH +: DATA_WIDTH])),
      .acc_o(acc_lane[gi])
    );
  end

  always_comb begin
    acc_sel  = acc_lane[j_q];
    prod_w   = PROD_W'(acc_sel) * PROD_W'($signed({1'b0, coeff_q}));
    req_full = requant_sat(REQ_W'(prod_w), relu_q, DATA_WIDTH);
    wr_data  = req_full[DATA_WIDTH-1:0];
  end

  assign buf_we = (state_q == ST_DRAIN);

  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_mem[oaddr_q] <= wr_data;
    end
  end

  // Separate read process: a same-address write in this cycle is seen next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= buf_mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign x_en_o    = (state_q == ST_ACC);
  assign w_en_o    = (state_q == ST_ACC);
  assign x_addr_o  = k_q;
  assign w_addr_o  = waddr_q;

endmodule
